mdio_target_cfg: RTL and testbench
==================================

# mdio_target_cfg

Parametrised MDIO (Clause 22) management target, clocked by MDC, that decodes frames issued by the station-side MDIO controller on MDIO_OUT/MDIO_OE. It replaces the fixed-count peripheral decoder with preamble/start validation, PHY-address filtering, a read-request handshake, an explicit drive-enable for the returned read data, and frame-error reporting. It sits between the MDIO bus pins and the PHY register file (ADDR/WR_DATA/WR_STB/RD_STB/RD_DATA).

## Interface
- PHY_ADDR, 5'd0: PHY address this target answers to.
- ADDR_MATCH_EN, 1: 1 = ignore frames whose PHYAD ≠ PHY_ADDR; 0 = answer every PHYAD.
- PRE_MIN, 32: minimum consecutive preamble ones required before ST (legal 0..32).

- MDC  in  1  MDIO clock; all logic on posedge.
- RESET  in  1  asynchronous, active-high reset.
- MDIO_OE  in  1  controller is driving the bus.
- MDIO_OUT  in  1  serial bit from controller.
- RD_DATA  in  16  register-file read data for ADDR.
- ADDR  out  5  register address for current access.
- WR_DATA  out  16  write data.
- WR_STB  out  1  one-cycle write strobe.
- RD_STB  out  1  one-cycle read request.
- MDIO_IN  out  1  serial read data to controller.
- MDIO_IN_OE  out  1  target is driving MDIO_IN.
- MDIO_DONE  out  1  one-cycle transaction-complete pulse.
- FRAME_ERR  out  1  one-cycle malformed-frame pulse.

## Operation
- Reset (any time, incl. mid-frame): all outputs 0, state IDLE, preamble count 0, shift registers 0.
- Frame, MSB first: PRE(≥PRE_MIN ones) ST=01 OP PHYAD[4:0] REGAD[4:0] TA DATA[15:0]. OP 10 = read, 01 = write.
- States: IDLE, ST1, OP, PHYAD, REGAD, TA_W, TA_R, WDATA, RDATA, SKIP.
- IDLE: MDIO_OE=0 clears pre_cnt; MDIO_OE=1 & bit 1 increments pre_cnt (saturates at 32); bit 0 with pre_cnt≥PRE_MIN → ST1, else pre_cnt←0, stay IDLE, no error.
- ST1: bit 1 → OP; bit 0 → FRAME_ERR, IDLE.
- OP: 2 bits; 00/11 → FRAME_ERR, IDLE after second bit.
- PHYAD, REGAD: 5 bits each shifted in.
- After last REGAD bit: PHYAD mismatch with ADDR_MATCH_EN=1 → SKIP (18 cycles, no outputs, no FRAME_ERR, then IDLE). Else write → TA_W; read → TA_R with ADDR←REGAD, RD_STB=1.
- TA_W: must sample 1 then 0; otherwise FRAME_ERR, IDLE. Then WDATA, 16 bits.
- WDATA last bit: WR_DATA←word, ADDR←REGAD, WR_STB=1 and MDIO_DONE=1 (one cycle), IDLE.
- TA_R: cycle 1 MDIO_IN_OE←1, MDIO_IN←0; cycle 2 RD_DATA latched, MDIO_IN←RD_DATA[15], enter RDATA.
- RDATA: MDIO_IN steps D14..D0, one per cycle; after D0 cycle MDIO_IN_OE←0, MDIO_IN←0, MDIO_DONE=1, IDLE.
- ADDR and WR_DATA hold their last value between transactions.
- Errors: MDIO_OE=0 in ST1/OP/PHYAD/REGAD/TA_W/WDATA → FRAME_ERR, IDLE, no strobe. MDIO_OE=1 on any edge where MDIO_IN_OE=1 (bus contention) → FRAME_ERR, MDIO_IN_OE←0, IDLE. SKIP ignores MDIO_OE.
- Back-to-back frames: IDLE re-entered with pre_cnt=0; PRE_MIN=0 permits ST immediately after DONE.

## Timing
- Edge E0 samples last REGAD bit → RD_STB high E0..E1; ADDR valid from E0.
- RD_DATA must be stable by E2 (two MDC cycles after RD_STB rises); sampled exactly once at E2.
- MDIO_IN: 0 during E1..E2, D15 E2..E3, …, D0 E17..E18; MDIO_IN_OE high E1..E18; MDIO_DONE high E18..E19.
- Write: WR_STB/MDIO_DONE/WR_DATA update at the edge sampling D0; strobes high exactly one cycle.
- Frame length: 32 + PRE cycles; no wait states.

## Test plan
- Write, PHY_ADDR=5'd3, 32 ones, ST 01, OP 01, PHYAD 3, REGAD 5'h0A, TA 10, data 16'hBEEF -> single WR_STB+MDIO_DONE cycle with ADDR=5'h0A, WR_DATA=16'hBEEF; FRAME_ERR never high.
- Read REGAD 5'h11, RD_DATA=16'hA5C3 supplied 2 cycles after RD_STB -> MDIO_IN_OE high 17 cycles, MDIO_IN = 0 then 1010010111000011, MDIO_DONE on last.
- PHYAD 5'd7 with PHY_ADDR=3, ADDR_MATCH_EN=1 -> no strobes, MDIO_IN_OE stays 0, no FRAME_ERR; next valid frame decoded normally.
- Only 10 preamble ones with PRE_MIN=32, then ST/OP/... -> frame ignored; OP=11 after full preamble -> FRAME_ERR one cycle; write TA 11 -> FRAME_ERR, no WR_STB.
- MDIO_OE high during read data bit D8 -> FRAME_ERR, MDIO_IN_OE drops next edge, no MDIO_DONE.
- RESET pulsed mid-WDATA -> all outputs 0 immediately (async), subsequent full write decoded correctly.

Source files
------------

// File: rtl/mdio_target_cfg.sv
// MDIO Clause 22 management target: decodes controller frames on MDC and drives
// the PHY register-file strobes plus the serial read-data return path.
module mdio_target_cfg #(
  parameter logic [4:0] PHY_ADDR      = 5'd0,
  parameter bit         ADDR_MATCH_EN = 1'b1,
  parameter int         PRE_MIN       = 32
) (
  input  logic        MDC,
  input  logic        RESET,
  input  logic        MDIO_OE,
  input  logic        MDIO_OUT,
  input  logic [15:0] RD_DATA,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  output logic        RD_STB,
  output logic        MDIO_IN,
  output logic        MDIO_IN_OE,
  output logic        MDIO_DONE,
  output logic        FRAME_ERR
);

  localparam logic [5:0] PRE_SAT = 6'd32;
  localparam logic [5:0] PRE_REQ = 6'(PRE_MIN);

  typedef enum logic [3:0] {
    S_IDLE, S_ST1, S_OP, S_PHYAD, S_REGAD,
    S_TA_W, S_TA_R, S_WDATA, S_RDATA, S_SKIP
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  phyad_q, phyad_d;
  logic [4:0]  regad_q, regad_d;
  logic [14:0] shift_q, shift_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        wr_stb_q, wr_stb_d;
  logic        rd_stb_q, rd_stb_d;
  logic        mdio_in_q, mdio_in_d;
  logic        mdio_in_oe_q, mdio_in_oe_d;
  logic        done_q, done_d;
  logic        frame_err_q, frame_err_d;

  logic [1:0]  op_shift;
  logic [4:0]  regad_shift;
  logic        ctrl_phase;

  assign op_shift    = {op_q[0], MDIO_OUT};
  assign regad_shift = {regad_q[3:0], MDIO_OUT};
  // Phases in which the controller must be actively driving the bus.
  assign ctrl_phase  = state_q inside {S_ST1, S_OP, S_PHYAD, S_REGAD, S_TA_W, S_WDATA};

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    op_d         = op_q;
    phyad_d      = phyad_q;
    regad_d      = regad_q;
    shift_d      = shift_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    mdio_in_d    = mdio_in_q;
    mdio_in_oe_d = mdio_in_oe_q;
    wr_stb_d     = 1'b0;
    rd_stb_d     = 1'b0;
    done_d       = 1'b0;
    frame_err_d  = 1'b0;

    if (mdio_in_oe_q && MDIO_OE) begin
      frame_err_d  = 1'b1;
      mdio_in_oe_d = 1'b0;
      mdio_in_d    = 1'b0;
      state_d      = S_IDLE;
    end else if (ctrl_phase && !MDIO_OE) begin
      frame_err_d = 1'b1;
      state_d     = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!MDIO_OE) begin
            pre_cnt_d = '0;
          end else if (MDIO_OUT) begin
            if (pre_cnt_q != PRE_SAT) pre_cnt_d = pre_cnt_q + 6'd1;
          end else begin
            pre_cnt_d = '0;
            if (pre_cnt_q >= PRE_REQ) state_d = S_ST1;
          end
        end
        S_ST1: begin
          if (MDIO_OUT) begin
            state_d   = S_OP;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
        S_OP: begin
          op_d = op_shift;
          if (bit_cnt_q == 5'd0) begin
            bit_cnt_d = 5'd1;
          end else if (op_shift == 2'b10 || op_shift == 2'b01) begin
            state_d   = S_PHYAD;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
        S_PHYAD: begin
          phyad_d = {phyad_q[3:0], MDIO_OUT};
          if (bit_cnt_q == 5'd4) begin
            state_d   = S_REGAD;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        S_REGAD: begin
          regad_d = regad_shift;
          if (bit_cnt_q == 5'd4) begin
            bit_cnt_d = '0;
            if (ADDR_MATCH_EN && phyad_q != PHY_ADDR) begin
              state_d = S_SKIP;
            end else if (op_q == 2'b01) begin
              state_d = S_TA_W;
            end else begin
              // Early read request gives the register file two cycles of lookup time.
              state_d  = S_TA_R;
              addr_d   = regad_shift;
              rd_stb_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        S_TA_W: begin
          if (bit_cnt_q == 5'd0 && MDIO_OUT) begin
            bit_cnt_d = 5'd1;
          end else if (bit_cnt_q == 5'd1 && !MDIO_OUT) begin
            state_d   = S_WDATA;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
        S_WDATA: begin
          shift_d = {shift_q[13:0], MDIO_OUT};
          if (bit_cnt_q == 5'd15) begin
            wr_data_d = {shift_q, MDIO_OUT};
            addr_d    = regad_q;
            wr_stb_d  = 1'b1;
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        S_TA_R: begin
          if (bit_cnt_q == 5'd0) begin
            mdio_in_oe_d = 1'b1;
            mdio_in_d    = 1'b0;
            bit_cnt_d    = 5'd1;
          end else begin
            mdio_in_d = RD_DATA[15];
            shift_d   = RD_DATA[14:0];
            state_d   = S_RDATA;
            bit_cnt_d = '0;
          end
        end
        S_RDATA: begin
          if (bit_cnt_q == 5'd15) begin
            mdio_in_oe_d = 1'b0;
            mdio_in_d    = 1'b0;
            done_d       = 1'b1;
            state_d      = S_IDLE;
          end else begin
            mdio_in_d = shift_q[14];
            shift_d   = {shift_q[13:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        S_SKIP: begin
          // Stay out of the way for the rest of a frame addressed to another PHY.
          if (bit_cnt_q == 5'd17) state_d = S_IDLE;
          else bit_cnt_d = bit_cnt_q + 5'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge MDC or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      pre_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      op_q         <= '0;
      phyad_q      <= '0;
      regad_q      <= '0;
      shift_q      <= '0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      wr_stb_q     <= 1'b0;
      rd_stb_q     <= 1'b0;
      mdio_in_q    <= 1'b0;
      mdio_in_oe_q <= 1'b0;
      done_q       <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      op_q         <= op_d;
      phyad_q      <= phyad_d;
      regad_q      <= regad_d;
      shift_q      <= shift_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      wr_stb_q     <= wr_stb_d;
      rd_stb_q     <= rd_stb_d;
      mdio_in_q    <= mdio_in_d;
      mdio_in_oe_q <= mdio_in_oe_d;
      done_q       <= done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign ADDR       = addr_q;
  assign WR_DATA    = wr_data_q;
  assign WR_STB     = wr_stb_q;
  assign RD_STB     = rd_stb_q;
  assign MDIO_IN    = mdio_in_q;
  assign MDIO_IN_OE = mdio_in_oe_q;
  assign MDIO_DONE  = done_q;
  assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_mdio_target_cfg.sv
// Self-checking bench for mdio_target_cfg: random frames are scripted per cycle and
// the expected strobes/serial data are derived from the frame timing rules.
module tb_mdio_target_cfg;

  localparam logic [4:0] MY_PHY = 5'd3;
  localparam int         MAXC   = 2048;
  localparam logic [5:0] F_WR   = 6'b100000;
  localparam logic [5:0] F_RD   = 6'b010000;
  localparam logic [5:0] F_DONE = 6'b001000;
  localparam logic [5:0] F_ERR  = 6'b000100;
  localparam logic [5:0] F_OE   = 6'b000010;
  localparam logic [5:0] F_IN   = 6'b000001;

  logic        mdc = 1'b0;
  logic        rst;
  logic        mdio_oe;
  logic        mdio_out;
  logic [15:0] rd_data;
  logic [4:0]  addr;
  logic [15:0] wr_data;
  logic        wr_stb, rd_stb, mdio_in, mdio_in_oe, mdio_done, frame_err;

  mdio_target_cfg #(.PHY_ADDR(MY_PHY), .ADDR_MATCH_EN(1'b1), .PRE_MIN(32)) dut (
    .MDC(mdc), .RESET(rst), .MDIO_OE(mdio_oe), .MDIO_OUT(mdio_out), .RD_DATA(rd_data),
    .ADDR(addr), .WR_DATA(wr_data), .WR_STB(wr_stb), .RD_STB(rd_stb),
    .MDIO_IN(mdio_in), .MDIO_IN_OE(mdio_in_oe), .MDIO_DONE(mdio_done), .FRAME_ERR(frame_err)
  );

  always #5 mdc = ~mdc;

  // Per-cycle script: stimulus, expected flag vector, and observations after each edge.
  logic        st_oe   [MAXC];
  logic        st_bit  [MAXC];
  logic [15:0] st_rd   [MAXC];
  logic [5:0]  ex_flags[MAXC];
  logic [5:0]  ob_flags[MAXC];
  logic [4:0]  ob_addr [MAXC];
  logic [15:0] ob_wdata[MAXC];
  int          ncyc;
  int          compared   = 0;
  int          mismatched = 0;

  task automatic push(input logic oe, input logic b);
    if (ncyc < MAXC) begin
      st_oe[ncyc]    = oe;
      st_bit[ncyc]   = b;
      st_rd[ncyc]    = 16'($urandom);
      ex_flags[ncyc] = '0;
      ncyc++;
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'($urandom));
  endtask

  task automatic push_hdr(input int pre, input logic [1:0] op, input logic [4:0] phy,
                          input logic [4:0] rega, output int e0);
    for (int i = 0; i < pre; i++) push(1'b1, 1'b1);
    push(1'b1, 1'b0);
    push(1'b1, 1'b1);
    push(1'b1, op[1]);
    push(1'b1, op[0]);
    for (int i = 4; i >= 0; i--) push(1'b1, phy[i]);
    for (int i = 4; i >= 0; i--) push(1'b1, rega[i]);
    e0 = ncyc - 1;
  endtask

  task automatic push_wtail(input logic [1:0] ta, input logic [15:0] d);
    push(1'b1, ta[1]);
    push(1'b1, ta[0]);
    for (int i = 15; i >= 0; i--) push(1'b1, d[i]);
  endtask

  task automatic push_rtail();
    for (int i = 0; i < 18; i++) push(1'b0, 1'($urandom));
  endtask

  // Reference timing: write completes on the edge sampling D0, 18 edges after the last REGAD bit.
  task automatic exp_write(input int e0);
    ex_flags[e0 + 18] = ex_flags[e0 + 18] | F_WR | F_DONE;
  endtask

  // Reference read: RD_STB at E0, turnaround 0 at E1, D15..D0 on E2..E17, DONE at E18.
  task automatic exp_read(input int e0, input logic [15:0] d);
    st_rd[e0 + 2] = d;
    ex_flags[e0]     = ex_flags[e0] | F_RD;
    ex_flags[e0 + 1] = ex_flags[e0 + 1] | F_OE;
    for (int j = 0; j < 16; j++)
      ex_flags[e0 + 2 + j] = ex_flags[e0 + 2 + j] | F_OE | (d[15 - j] ? F_IN : 6'b0);
    ex_flags[e0 + 18] = ex_flags[e0 + 18] | F_DONE;
  endtask

  task automatic run();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge mdc);
      mdio_oe  = st_oe[i];
      mdio_out = st_bit[i];
      rd_data  = st_rd[i];
      @(posedge mdc);
      #1;
      ob_flags[i] = {wr_stb, rd_stb, mdio_done, frame_err, mdio_in_oe, mdio_in};
      ob_addr[i]  = addr;
      ob_wdata[i] = wr_data;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mdio_oe = 1'b0; mdio_out = 1'b0; rd_data = '0;
    repeat (3) @(posedge mdc);
    #1;
    compared++;
    if ({addr, wr_data, wr_stb, rd_stb, mdio_in, mdio_in_oe, mdio_done, frame_err} !== 27'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {addr, wr_data, wr_stb, rd_stb, mdio_in, mdio_in_oe, mdio_done, frame_err});
    end
    @(negedge mdc);
    rst = 1'b0;
    ncyc = 0;
    push_idle(6);
    run();
    for (int i = 0; i < ncyc; i++) begin
      compared++;
      if (ob_flags[i] !== ex_flags[i]) begin
        mismatched++;
        $display("FAIL reset_idle_flags cycle %0d: got %b, expected %b", i, ob_flags[i], ex_flags[i]);
      end
    end
  endtask

  task automatic test_write();
    int e0s[4];
    logic [4:0]  regs[4];
    logic [15:0] dats[4];
    ncyc = 0;
    push_idle(4);
    for (int k = 0; k < 4; k++) begin
      regs[k] = (k == 0) ? 5'h0A : 5'($urandom);
      dats[k] = (k == 0) ? 16'hBEEF : 16'($urandom);
      push_hdr((k == 0) ? 32 : int'($urandom_range(32, 40)), 2'b01, MY_PHY, regs[k], e0s[k]);
      push_wtail(2'b10, dats[k]);
      exp_write(e0s[k]);
      push_idle(int'($urandom_range(0, 3)));
    end
    push_idle(3);
    run();
    for (int i = 0; i < ncyc; i++) begin
      compared++;
      if (ob_flags[i] !== ex_flags[i]) begin
        mismatched++;
        $display("FAIL write_flags cycle %0d: got %b, expected %b", i, ob_flags[i], ex_flags[i]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      compared++;
      if ({ob_addr[e0s[k] + 18], ob_wdata[e0s[k] + 18]} !== {regs[k], dats[k]}) begin
        mismatched++;
        $display("FAIL write_data frame %0d: got addr %h data %h, expected addr %h data %h",
                 k, ob_addr[e0s[k] + 18], ob_wdata[e0s[k] + 18], regs[k], dats[k]);
      end
    end
    compared++;
    if ({ob_addr[ncyc - 1], ob_wdata[ncyc - 1]} !== {regs[3], dats[3]}) begin
      mismatched++;
      $display("FAIL write_hold: got addr %h data %h, expected addr %h data %h",
               ob_addr[ncyc - 1], ob_wdata[ncyc - 1], regs[3], dats[3]);
    end
  endtask

  task automatic test_read();
    int e0s[4];
    logic [4:0]  regs[4];
    logic [15:0] dats[4];
    ncyc = 0;
    push_idle(3);
    for (int k = 0; k < 4; k++) begin
      regs[k] = (k == 0) ? 5'h11 : 5'($urandom);
      dats[k] = (k == 0) ? 16'hA5C3 : 16'($urandom);
      push_hdr((k == 0) ? 32 : int'($urandom_range(32, 40)), 2'b10, MY_PHY, regs[k], e0s[k]);
      push_rtail();
      exp_read(e0s[k], dats[k]);
      push_idle(int'($urandom_range(0, 3)));
    end
    push_idle(3);
    run();
    for (int i = 0; i < ncyc; i++) begin
      compared++;
      if (ob_flags[i] !== ex_flags[i]) begin
        mismatched++;
        $display("FAIL read_flags cycle %0d: got %b, expected %b", i, ob_flags[i], ex_flags[i]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (ob_addr[e0s[k]] !== regs[k] || ob_addr[e0s[k] + 18] !== regs[k]) begin
        mismatched++;
        $display("FAIL read_addr frame %0d: got %h/%h, expected %h",
                 k, ob_addr[e0s[k]], ob_addr[e0s[k] + 18], regs[k]);
      end
    end
  endtask

  task automatic test_phy_filter();
    int e0a, e0b, e0x;
    logic [4:0]  rega, regb, phy;
    logic [15:0] data, datb;
    rega = 5'($urandom) | 5'd1;
    data = 16'($urandom);
    regb = 5'($urandom);
    datb = 16'($urandom);
    ncyc = 0;
    push_idle(3);
    push_hdr(32, 2'b01, MY_PHY, rega, e0a);
    push_wtail(2'b10, data);
    exp_write(e0a);
    push_hdr(32, 2'b01, 5'd7, 5'($urandom), e0x);
    push_wtail(2'b10, 16'($urandom));
    push_hdr(34, 2'b10, 5'd7, 5'($urandom), e0x);
    push_rtail();
    phy = 5'($urandom);
    if (phy == MY_PHY) phy = phy + 5'd1;
    push_hdr(33, 2'b01, phy, 5'($urandom), e0x);
    push_wtail(2'b10, 16'($urandom));
    push_hdr(32, 2'b10, MY_PHY, regb, e0b);
    push_rtail();
    exp_read(e0b, datb);
    push_idle(3);
    run();
    for (int i = 0; i < ncyc; i++) begin
      compared++;
      if (ob_flags[i] !== ex_flags[i]) begin
        mismatched++;
        $display("FAIL filter_flags cycle %0d: got %b, expected %b", i, ob_flags[i], ex_flags[i]);
      end
    end
    compared++;
    if ({ob_addr[e0b - 1], ob_wdata[e0b - 1]} !== {rega, data}) begin
      mismatched++;
      $display("FAIL filter_hold: got addr %h data %h, expected addr %h data %h",
               ob_addr[e0b - 1], ob_wdata[e0b - 1], rega, data);
    end
    compared++;
    if (ob_addr[e0b] !== regb) begin
      mismatched++;
      $display("FAIL filter_read_addr: got %h, expected %h", ob_addr[e0b], regb);
    end
  endtask

  task automatic test_frame_errors();
    int e0;
    logic [4:0]  regv;
    logic [15:0] datv;
    ncyc = 0;
    push_idle(3);
    // Too-short preamble: whole frame ignored.
    push_hdr(10, 2'b01, MY_PHY, 5'($urandom), e0);
    push_wtail(2'b10, 16'($urandom));
    push_idle(2);
    // ST of 00.
    for (int i = 0; i < 32; i++) push(1'b1, 1'b1);
    push(1'b1, 1'b0);
    push(1'b1, 1'b0);
    ex_flags[ncyc - 1] = F_ERR;
    push_idle(2);
    // OP 11 and OP 00: error on the second OP bit.
    push_hdr(32, 2'b11, MY_PHY, 5'($urandom), e0);
    ex_flags[e0 - 10] = F_ERR;
    push_wtail(2'b10, 16'($urandom));
    push_idle(2);
    push_hdr(35, 2'b00, MY_PHY, 5'($urandom), e0);
    ex_flags[e0 - 10] = F_ERR;
    push_wtail(2'b10, 16'($urandom));
    push_idle(2);
    // Write turnaround 11, then 00.
    push_hdr(32, 2'b01, MY_PHY, 5'($urandom), e0);
    push_wtail(2'b11, 16'($urandom));
    ex_flags[e0 + 2] = F_ERR;
    push_idle(2);
    push_hdr(32, 2'b01, MY_PHY, 5'($urandom), e0);
    push_wtail(2'b00, 16'($urandom));
    ex_flags[e0 + 1] = F_ERR;
    push_idle(2);
    // Controller releases the bus in the middle of PHYAD.
    push_hdr(32, 2'b01, MY_PHY, 5'($urandom), e0);
    st_oe[e0 - 7] = 1'b0;
    ex_flags[e0 - 7] = F_ERR;
    push_wtail(2'b10, 16'($urandom));
    push_idle(2);
    // Recovery with a clean write.
    regv = 5'($urandom);
    datv = 16'($urandom);
    push_hdr(32, 2'b01, MY_PHY, regv, e0);
    push_wtail(2'b10, datv);
    exp_write(e0);
    push_idle(3);
    run();
    for (int i = 0; i < ncyc; i++) begin
      compared++;
      if (ob_flags[i] !== ex_flags[i]) begin
        mismatched++;
        $display("FAIL errors_flags cycle %0d: got %b, expected %b", i, ob_flags[i], ex_flags[i]);
      end
    end
    compared++;
    if ({ob_addr[e0 + 18], ob_wdata[e0 + 18]} !== {regv, datv}) begin
      mismatched++;
      $display("FAIL errors_recovery_data: got addr %h data %h, expected addr %h data %h",
               ob_addr[e0 + 18], ob_wdata[e0 + 18], regv, datv);
    end
  endtask

  task automatic test_contention();
    int e0;
    logic [15:0] d;
    d = 16'($urandom);
    ncyc = 0;
    push_idle(3);
    push_hdr(32, 2'b10, MY_PHY, 5'($urandom), e0);
    push_rtail();
    // Controller drives while D8 is on the wire; expected trace ends at that edge.
    st_oe[e0 + 10] = 1'b1;
    ex_flags[e0]     = F_RD;
    ex_flags[e0 + 1] = F_OE;
    for (int j = 0; j < 8; j++) ex_flags[e0 + 2 + j] = F_OE | (d[15 - j] ? F_IN : 6'b0);
    st_rd[e0 + 2] = d;
    ex_flags[e0 + 10] = F_ERR;
    push_idle(2);
    d = 16'($urandom);
    push_hdr(32, 2'b10, MY_PHY, 5'($urandom), e0);
    push_rtail();
    exp_read(e0, d);
    push_idle(3);
    run();
    for (int i = 0; i < ncyc; i++) begin
      compared++;
      if (ob_flags[i] !== ex_flags[i]) begin
        mismatched++;
        $display("FAIL contention_flags cycle %0d: got %b, expected %b", i, ob_flags[i], ex_flags[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    logic [4:0]  regv;
    logic [15:0] datv;
    ncyc = 0;
    push_idle(2);
    push_hdr(32, 2'b01, MY_PHY, 5'h15, e0);
    push_wtail(2'b10, 16'h1234);
    exp_write(e0);
    push_hdr(33, 2'b01, MY_PHY, 5'h09, e0);
    push(1'b1, 1'b1);
    push(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) push(1'b1, 1'($urandom));
    run();
    for (int i = 0; i < ncyc; i++) begin
      compared++;
      if (ob_flags[i] !== ex_flags[i]) begin
        mismatched++;
        $display("FAIL midreset_pre_flags cycle %0d: got %b, expected %b", i, ob_flags[i], ex_flags[i]);
      end
    end
    @(negedge mdc);
    rst = 1'b1;
    #1;
    compared++;
    if ({addr, wr_data, wr_stb, rd_stb, mdio_in, mdio_in_oe, mdio_done, frame_err} !== 27'd0) begin
      mismatched++;
      $display("FAIL midreset_async_clear: got %h, expected 0",
               {addr, wr_data, wr_stb, rd_stb, mdio_in, mdio_in_oe, mdio_done, frame_err});
    end
    @(posedge mdc);
    @(negedge mdc);
    rst = 1'b0;
    regv = 5'($urandom);
    datv = 16'($urandom);
    ncyc = 0;
    push_idle(3);
    push_hdr(32, 2'b01, MY_PHY, regv, e0);
    push_wtail(2'b10, datv);
    exp_write(e0);
    push_idle(3);
    run();
    for (int i = 0; i < ncyc; i++) begin
      compared++;
      if (ob_flags[i] !== ex_flags[i]) begin
        mismatched++;
        $display("FAIL midreset_post_flags cycle %0d: got %b, expected %b", i, ob_flags[i], ex_flags[i]);
      end
    end
    compared++;
    if ({ob_addr[e0 + 18], ob_wdata[e0 + 18]} !== {regv, datv}) begin
      mismatched++;
      $display("FAIL midreset_post_data: got addr %h data %h, expected addr %h data %h",
               ob_addr[e0 + 18], ob_wdata[e0 + 18], regv, datv);
    end
  endtask

  task automatic test_back_to_back();
    int          e0q[$];
    logic [4:0]  regq[$];
    logic [15:0] datq[$];
    logic        isrd[$];
    int          e0;
    logic [4:0]  r;
    logic [15:0] d;
    logic        rdop;
    ncyc = 0;
    push_idle(2);
    for (int k = 0; k < 8; k++) begin
      r    = 5'($urandom);
      d    = 16'($urandom);
      rdop = 1'($urandom);
      push_hdr(int'($urandom_range(32, 36)), rdop ? 2'b10 : 2'b01, MY_PHY, r, e0);
      if (rdop) begin
        push_rtail();
        exp_read(e0, d);
      end else begin
        push_wtail(2'b10, d);
        exp_write(e0);
      end
      e0q.push_back(e0);
      regq.push_back(r);
      datq.push_back(d);
      isrd.push_back(rdop);
    end
    push_idle(3);
    run();
    for (int i = 0; i < ncyc; i++) begin
      compared++;
      if (ob_flags[i] !== ex_flags[i]) begin
        mismatched++;
        $display("FAIL b2b_flags cycle %0d: got %b, expected %b", i, ob_flags[i], ex_flags[i]);
      end
    end
    for (int k = 0; k < e0q.size(); k++) begin
      compared++;
      if (ob_addr[e0q[k] + 18] !== regq[k] ||
          (!isrd[k] && ob_wdata[e0q[k] + 18] !== datq[k])) begin
        mismatched++;
        $display("FAIL b2b_data frame %0d: got addr %h data %h, expected addr %h data %h (read=%0b)",
                 k, ob_addr[e0q[k] + 18], ob_wdata[e0q[k] + 18], regq[k], datq[k], isrd[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_phy_filter();
    test_frame_errors();
    test_contention();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected end of test sequence");
    $fatal(1, "timeout");
  end

endmodule
